// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the normalised-result record handed to the rounding stage.
package fp32_pkg;

   localparam int FP32_EXP_W = 8;
   localparam int FP32_SIG_W = 24;
   localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'd255;

   typedef struct packed {
      logic                  sign;
      logic [FP32_EXP_W-1:0] exp;
      logic [FP32_SIG_W-1:0] mant;
      logic                  sticky;
      logic                  zero;
      logic                  underflow;
      logic                  overflow;
   } fp32_norm_t;

endpackage

// File: rtl/comparator_5bit.sv
// 5-bit unsigned magnitude comparator: gt = (a > b).
module comparator_5bit (
   input  logic [4:0] a,
   input  logic [4:0] b,
   output logic       gt
);

   assign gt = (a > b);

endmodule

// File: rtl/fp32_lzc24.sv
// Priority leading-zero counter over a 24-bit significand; returns 24 for an all-zero field.
module fp32_lzc24 (
   input  logic [23:0] mant,
   output logic [4:0]  count
);

   always_comb begin
      count = 5'd24;
      // Ascending scan so the highest set bit has the final say.
      for (int i = 0; i < 24; i++) begin
         if (mant[i]) begin
            count = 5'(23 - i);
         end
      end
   end

endmodule

// File: rtl/fp32_norm_stage.sv
// Two-stage normalisation for the FP32 add/sub datapath: S1 captures the sum plus its
// leading-zero count, S2 picks carry / zero / normal / subnormal handling and registers it.
module fp32_norm_stage
   import fp32_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_sign,
   input  logic [FP32_EXP_W-1:0] i_exp,
   input  logic [FP32_SIG_W:0]   i_mant,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_sign,
   output logic [FP32_EXP_W-1:0] o_exp,
   output logic [FP32_SIG_W-1:0] o_mant,
   output logic                  o_sticky,
   output logic                  o_zero,
   output logic                  o_underflow,
   output logic                  o_overflow
);

   logic                  s1_valid_reg;
   logic                  s1_sign_reg;
   logic [FP32_EXP_W-1:0] s1_exp_reg;
   logic [FP32_SIG_W:0]   s1_mant_reg;
   logic [4:0]            s1_lzc_reg;
   logic                  s1_carry_reg;

   logic                  s2_valid_reg;
   fp32_norm_t            s2_reg;
   fp32_norm_t            s2_next;

   logic                  s1_load;
   logic                  s2_load;
   logic [4:0]            in_lzc;

   logic                  cmp_gt;
   logic                  exp_hi;
   logic                  exp_gt;
   logic                  mant_is_zero;
   logic [4:0]            shift_amt;
   logic [FP32_SIG_W-1:0] mant_shifted;
   logic [FP32_EXP_W:0]   exp_inc;

   // Pipeline advance: no skid buffer, so o_ready is combinational from i_ready.
   assign s2_load = ~s2_valid_reg | i_ready;
   assign s1_load = ~s1_valid_reg | s2_load;
   assign o_ready = s1_load;

   fp32_lzc24 u_lzc (
      .mant  (i_mant[FP32_SIG_W-1:0]),
      .count (in_lzc)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_sign_reg  <= 1'b0;
         s1_exp_reg   <= '0;
         s1_mant_reg  <= '0;
         s1_lzc_reg   <= '0;
         s1_carry_reg <= 1'b0;
      end else if (s1_load) begin
         s1_valid_reg <= i_valid;
         s1_sign_reg  <= i_sign;
         s1_exp_reg   <= i_exp;
         s1_mant_reg  <= i_mant;
         s1_lzc_reg   <= in_lzc;
         s1_carry_reg <= i_mant[FP32_SIG_W];
      end
   end

   comparator_5bit u_cmp (
      .a  (s1_exp_reg[4:0]),
      .b  (s1_lzc_reg),
      .gt (cmp_gt)
   );

   // Exponents of 32 and up always exceed any possible lzc (max 24).
   assign exp_hi       = |s1_exp_reg[FP32_EXP_W-1:5];
   assign exp_gt       = exp_hi | cmp_gt;
   assign mant_is_zero = (s1_mant_reg == '0);
   assign exp_inc      = {1'b0, s1_exp_reg} + 9'd1;

   // Subnormal path clamps the shift at exp-1 so the exponent lands exactly on the floor.
   always_comb begin
      shift_amt = 5'd0;
      if (exp_gt) begin
         shift_amt = s1_lzc_reg;
      end else if (s1_exp_reg != '0) begin
         shift_amt = s1_exp_reg[4:0] - 5'd1;
      end
   end

   assign mant_shifted = s1_mant_reg[FP32_SIG_W-1:0] << shift_amt;

   always_comb begin
      s2_next      = '0;
      s2_next.sign = s1_sign_reg;
      if (s1_carry_reg) begin
         if (exp_inc >= {1'b0, FP32_EXP_MAX}) begin
            s2_next.exp      = FP32_EXP_MAX;
            s2_next.overflow = 1'b1;
         end else begin
            s2_next.exp    = exp_inc[FP32_EXP_W-1:0];
            s2_next.mant   = s1_mant_reg[FP32_SIG_W:1];
            s2_next.sticky = s1_mant_reg[0];
         end
      end else if (mant_is_zero) begin
         s2_next.zero = 1'b1;
      end else if (exp_gt) begin
         s2_next.exp  = s1_exp_reg - {3'b000, s1_lzc_reg};
         s2_next.mant = mant_shifted;
      end else begin
         s2_next.mant      = mant_shifted;
         s2_next.underflow = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_reg       <= '0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         s2_reg       <= s2_next;
      end
   end

   assign o_valid     = s2_valid_reg;
   assign o_sign      = s2_reg.sign;
   assign o_exp       = s2_reg.exp;
   assign o_mant      = s2_reg.mant;
   assign o_sticky    = s2_reg.sticky;
   assign o_zero      = s2_reg.zero;
   assign o_underflow = s2_reg.underflow;
   assign o_overflow  = s2_reg.overflow;

endmodule

// File: tb/tb_fp32_norm_stage.sv
// Scoreboard bench for fp32_norm_stage: directed vectors, backpressure, random traffic, reset.
module tb_fp32_norm_stage;
   import fp32_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_sign = 1'b0;
   logic [7:0]  i_exp = '0;
   logic [24:0] i_mant = '0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic        o_sign;
   logic [7:0]  o_exp;
   logic [23:0] o_mant;
   logic        o_sticky;
   logic        o_zero;
   logic        o_underflow;
   logic        o_overflow;

   int checks_cnt = 0;
   int errors_cnt = 0;
   int out_cnt = 0;
   fp32_norm_t drv_exp = '0;
   fp32_norm_t sb[$];

   fp32_norm_stage dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_sign      (i_sign),
      .i_exp       (i_exp),
      .i_mant      (i_mant),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_sign      (o_sign),
      .o_exp       (o_exp),
      .o_mant      (o_mant),
      .o_sticky    (o_sticky),
      .o_zero      (o_zero),
      .o_underflow (o_underflow),
      .o_overflow  (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks_cnt++;
      if (obs !== req) begin
         errors_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, req);
      end
   endtask

   function automatic fp32_norm_t mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                     input logic st, input logic z, input logic uf, input logic ov);
      fp32_norm_t r;
      r.sign = s; r.exp = e; r.mant = m; r.sticky = st;
      r.zero = z; r.underflow = uf; r.overflow = ov;
      return r;
   endfunction

   // Reference: integer exponent arithmetic and a bit-walk for the leading zeros.
   function automatic fp32_norm_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
      fp32_norm_t r = '0;
      int ei = int'(e);
      int lz = 0;
      r.sign = s;
      if (m[24]) begin
         if (ei + 1 >= 255) begin
            r.exp = 8'd255; r.overflow = 1'b1;
         end else begin
            r.exp = 8'(ei + 1); r.mant = m[24:1]; r.sticky = m[0];
         end
      end else if (m == 25'd0) begin
         r.zero = 1'b1;
      end else begin
         while (m[23 - lz] == 1'b0) lz++;
         if (ei > lz) begin
            r.mant = m[23:0] << lz; r.exp = 8'(ei - lz);
         end else if (ei >= 1) begin
            r.mant = m[23:0] << (ei - 1); r.underflow = 1'b1;
         end else begin
            r.mant = m[23:0]; r.underflow = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic fp32_norm_t cur_out();
      return mk(o_sign, o_exp, o_mant, o_sticky, o_zero, o_underflow, o_overflow);
   endfunction

   task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] m, input fp32_norm_t x);
      i_valid = 1'b1; i_sign = s; i_exp = e; i_mant = m; drv_exp = x;
   endtask

   // Drive one beat and hold it until accepted; returns at the following negedge.
   task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input fp32_norm_t x);
      bit done = 0;
      drive(s, e, m, x);
      for (int k = 0; k < 50 && !done; k++) begin
         #1;
         done = o_ready;
         @(negedge i_clk);
      end
      if (!done) check("send_timeout", 0, 1);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge i_clk);
      check("drain_empty", 64'(sb.size()), 0);
   endtask

   // Monitor: samples mid-low-phase, pushes accepted beats, pops and compares drained ones.
   initial begin
      fp32_norm_t req;
      forever begin
         @(negedge i_clk);
         #3;
         if (!i_rst_n) begin
            sb.delete();
         end else begin
            if (i_valid && o_ready) sb.push_back(drv_exp);
            if (o_valid && i_ready) begin
               out_cnt++;
               $display("out %0d: sign=%0b exp=%0d mant=%06h st=%0b z=%0b uf=%0b ov=%0b",
                        out_cnt, o_sign, o_exp, o_mant, o_sticky, o_zero, o_underflow, o_overflow);
               if (sb.size() == 0) begin
                  check("unexpected_output", 1, 0);
               end else begin
                  req = sb.pop_front();
                  check("result", 64'(cur_out()), 64'(req));
               end
            end
         end
      end
   end

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [24:0] m;
      fp32_norm_t  x;
   } vec_t;

   vec_t dir[$];
   vec_t bp[4];

   initial begin
      // ---- reset state ----
      repeat (3) @(negedge i_clk);
      #1;
      check("rst_valid", 64'(o_valid), 0);
      check("rst_ready", 64'(o_ready), 1);
      check("rst_outputs", 64'(cur_out()), 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // ---- directed vectors ----
      dir.push_back('{1'b0, 8'd130, 25'h0800000, mk(0, 8'd130, 24'h800000, 0, 0, 0, 0)});
      dir.push_back('{1'b0, 8'd127, 25'h1000001, mk(0, 8'd128, 24'h800000, 1, 0, 0, 0)});
      dir.push_back('{1'b1, 8'd100, 25'h0000100, mk(1, 8'd85,  24'h800000, 0, 0, 0, 0)});
      dir.push_back('{1'b0, 8'd254, 25'h1000000, mk(0, 8'd255, 24'h000000, 0, 0, 0, 1)});
      dir.push_back('{1'b0, 8'd5,   25'h0000100, mk(0, 8'd0,   24'h001000, 0, 0, 1, 0)});
      dir.push_back('{1'b0, 8'd0,   25'h0000000, mk(0, 8'd0,   24'h000000, 0, 1, 0, 0)});
      dir.push_back('{1'b1, 8'd0,   25'h0000F00, mk(1, 8'd0,   24'h000F00, 0, 0, 1, 0)});
      dir.push_back('{1'b0, 8'd16,  25'h0000100, mk(0, 8'd1,   24'h800000, 0, 0, 0, 0)});
      dir.push_back('{1'b0, 8'd15,  25'h0000100, mk(0, 8'd0,   24'h400000, 0, 0, 1, 0)});
      dir.push_back('{1'b0, 8'd40,  25'h0000001, mk(0, 8'd17,  24'h800000, 0, 0, 0, 0)});
      dir.push_back('{1'b0, 8'd1,   25'h0000001, mk(0, 8'd0,   24'h000001, 0, 0, 1, 0)});
      dir.push_back('{1'b1, 8'd200, 25'h1FFFFFE, mk(1, 8'd201, 24'hFFFFFF, 0, 0, 0, 0)});
      i_ready = 1'b1;
      foreach (dir[i]) send(dir[i].s, dir[i].e, dir[i].m, dir[i].x);
      drain();

      // ---- backpressure: i_ready low for 4 cycles while 4 beats are offered ----
      bp[0] = '{1'b0, 8'd130, 25'h0800000, mk(0, 8'd130, 24'h800000, 0, 0, 0, 0)};
      bp[1] = '{1'b0, 8'd127, 25'h1000001, mk(0, 8'd128, 24'h800000, 1, 0, 0, 0)};
      bp[2] = '{1'b0, 8'd100, 25'h0000100, mk(0, 8'd85,  24'h800000, 0, 0, 0, 0)};
      bp[3] = '{1'b0, 8'd5,   25'h0000100, mk(0, 8'd0,   24'h001000, 0, 0, 1, 0)};
      begin
         int idx = 0;
         bit acc;
         for (int c = 0; c < 10; c++) begin
            i_ready = (c >= 4);
            if (idx < 4) drive(bp[idx].s, bp[idx].e, bp[idx].m, bp[idx].x);
            else i_valid = 1'b0;
            #1;
            acc = i_valid && o_ready;
            if (c == 1) check("bp_ready_c1", 64'(o_ready), 1);
            if (c == 2 || c == 3) begin
               check("bp_ready_low", 64'(o_ready), 0);
               check("bp_hold_valid", 64'(o_valid), 1);
               check("bp_hold_data", 64'(cur_out()), 64'(bp[0].x));
            end
            if (c >= 4 && c <= 7) check("bp_no_gap", 64'(o_valid), 1);
            if (c == 8) check("bp_empty", 64'(o_valid), 0);
            @(negedge i_clk);
            if (acc) idx++;
         end
         i_valid = 1'b0;
      end
      drain();

      // ---- random traffic with random backpressure ----
      begin
         bit pend = 0;
         logic        rs;
         logic [7:0]  re;
         logic [24:0] rm;
         for (int c = 0; c < 400; c++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if (!pend && $urandom_range(0, 3) != 0) begin
               rs = 1'($urandom_range(0, 1));
               case ($urandom_range(0, 3))
                  0: re = 8'($urandom_range(0, 30));
                  1: re = 8'($urandom_range(248, 254));
                  default: re = 8'($urandom_range(0, 254));
               endcase
               case ($urandom_range(0, 4))
                  0: rm = {1'b1, 24'($urandom)};
                  1: rm = 25'd0;
                  default: rm = {1'b0, 24'($urandom) >> $urandom_range(0, 23)};
               endcase
               drive(rs, re, rm, model(rs, re, rm));
               pend = 1;
            end
            i_valid = pend;
            #1;
            if (pend && o_ready) begin
               @(negedge i_clk);
               pend = 0;
               i_valid = 1'b0;
            end else begin
               @(negedge i_clk);
            end
         end
         i_valid = 1'b0;
         i_ready = 1'b1;
      end
      drain();

      // ---- reset with both stages full ----
      i_ready = 1'b0;
      drive(1'b0, 8'd130, 25'h0800000, mk(0, 8'd130, 24'h800000, 0, 0, 0, 0));
      @(negedge i_clk);
      drive(1'b0, 8'd127, 25'h1000001, mk(0, 8'd128, 24'h800000, 1, 0, 0, 0));
      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      check("prerst_full_valid", 64'(o_valid), 1);
      check("prerst_full_ready", 64'(o_ready), 0);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      #1;
      check("midrst_valid", 64'(o_valid), 0);
      check("midrst_ready", 64'(o_ready), 1);
      check("midrst_outputs", 64'(cur_out()), 0);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      @(negedge i_clk);
      drive(1'b1, 8'd100, 25'h0000100, mk(1, 8'd85, 24'h800000, 0, 0, 0, 0));
      #1;
      check("postrst_ready", 64'(o_ready), 1);
      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      check("postrst_lat1", 64'(o_valid), 0);
      @(negedge i_clk);
      #1;
      check("postrst_lat2", 64'(o_valid), 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
